// File: rtl/prog_encoder_loader.sv
// Program loader: packs symbolic MIPS commands into 32-bit words and writes them
// sequentially into instruction memory, holding the CPU while loading.
module prog_encoder_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words
);

  localparam int unsigned        WORDS_W  = ADDR_W + 1;
  localparam logic [WORDS_W-1:0] LAST_IDX = WORDS_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_was_last;
  logic                r_cmd_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_hold;
  logic                r_done;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic [WORDS_W-1:0]  r_words;

  logic                w_accept;
  logic                w_legal;
  logic [31:0]         w_enc;

  // Pack one command into its MIPS machine word.
  function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = 32'd0;
    case (kind)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      4'd2:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      4'd3:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      4'd4:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100110};
      4'd5:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      4'd6:    w = {6'b000000, rs, 15'd0, 6'b001000};
      4'd7:    w = {6'b100011, rs, rt, imm};
      4'd8:    w = {6'b101011, rs, rt, imm};
      4'd9:    w = {6'b001000, rs, rt, imm};
      4'd10:   w = {6'b001100, rs, rt, imm};
      4'd11:   w = {6'b001101, rs, rt, imm};
      4'd12:   w = {6'b000100, rs, rt, imm};
      4'd13:   w = {6'b000101, rs, rt, imm};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  assign w_accept = cmd_valid & r_cmd_ready;
  assign w_legal  = (cmd_kind <= 4'd13);
  assign w_enc    = encode(cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm);

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_was_last  <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_hold      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
      r_words     <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_cmd_ready <= 1'b1;
            r_hold      <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_words     <= '0;
            r_was_last  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (!w_legal) begin
              r_state     <= S_ERR;
              r_cmd_ready <= 1'b0;
              r_hold      <= 1'b0;
              r_err       <= 1'b1;
              r_err_code  <= 2'd1;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= r_words[ADDR_W-1:0];
              r_wdata <= w_enc;
              r_words <= r_words + WORDS_W'(1);
              // Final slot is still written; overflow is judged in DRAIN.
              if (cmd_last || (r_words == LAST_IDX)) begin
                r_state     <= S_DRAIN;
                r_cmd_ready <= 1'b0;
                r_was_last  <= cmd_last;
              end
            end
          end
        end
        S_DRAIN: begin
          r_hold <= 1'b0;
          if (r_was_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= 2'd2;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b0;
          r_hold      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_hold   = r_hold;
  assign done       = r_done;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign words      = r_words;

endmodule
